// File: rtl/host_mem_wr_burst_arbiter_if.sv
// host_mem_wr_burst_arbiter_if: requester-side and host_mem write-channel signals of the burst arbiter.
// master = engines/host side, slave = arbiter.
interface host_mem_wr_burst_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 42,
    parameter int DATA_WIDTH = 512,
    parameter int BURST_W    = 3,
    parameter int USER_WIDTH = 8
);
    logic [NUM_REQ-1:0]              req_write;
    logic [NUM_REQ*ADDR_WIDTH-1:0]   req_address;
    logic [NUM_REQ*DATA_WIDTH-1:0]   req_writedata;
    logic [NUM_REQ*BURST_W-1:0]      req_burstcount;
    logic [NUM_REQ*DATA_WIDTH/8-1:0] req_byteenable;
    logic [NUM_REQ-1:0]              req_waitrequest;
    logic [NUM_REQ-1:0]              req_wr_rsp_valid;
    logic                            wr_write;
    logic [ADDR_WIDTH-1:0]           wr_address;
    logic [DATA_WIDTH-1:0]           wr_writedata;
    logic [BURST_W-1:0]              wr_burstcount;
    logic [DATA_WIDTH/8-1:0]         wr_byteenable;
    logic [USER_WIDTH-1:0]           wr_user;
    logic                            wr_waitrequest;
    logic                            wr_rsp_valid;
    logic [USER_WIDTH-1:0]           wr_rsp_user;

    modport master (
        output req_write, req_address, req_writedata, req_burstcount, req_byteenable,
        output wr_waitrequest, wr_rsp_valid, wr_rsp_user,
        input  req_waitrequest, req_wr_rsp_valid,
        input  wr_write, wr_address, wr_writedata, wr_burstcount, wr_byteenable, wr_user
    );

    modport slave (
        input  req_write, req_address, req_writedata, req_burstcount, req_byteenable,
        input  wr_waitrequest, wr_rsp_valid, wr_rsp_user,
        output req_waitrequest, req_wr_rsp_valid,
        output wr_write, wr_address, wr_writedata, wr_burstcount, wr_byteenable, wr_user
    );
endinterface

// File: rtl/host_mem_wr_burst_arbiter.sv
// host_mem_wr_burst_arbiter: round-robin, burst-granular sharing of one host_mem write channel.
// Define ARB_WR_STATS_EN to add per-requester saturating accepted-burst counters on stat_bursts.
module host_mem_wr_burst_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 42,
    parameter int DATA_WIDTH = 512,
    parameter int BURST_W    = 3,
    parameter int USER_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    host_mem_wr_burst_arbiter_if.slave bus,
    input  logic [$clog2(NUM_REQ)-1:0] stat_sel,
    output logic [31:0]                stat_bursts
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int BE_W  = DATA_WIDTH / 8;

    typedef enum logic {IDLE, BURST} state_t;

    state_t               state, nstate;
    logic [IDX_W-1:0]     rr_ptr, n_rr_ptr, owner, n_owner, grant, sel;
    logic [BURST_W-1:0]   beats_left, n_beats_left, first_len;
    logic [2*NUM_REQ-1:0] rotated;
    logic                 found, accept;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return IDX_W'((int'(i) + 1) % NUM_REQ);
    endfunction

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            owner      <= '0;
            beats_left <= '0;
        end else begin
            state      <= nstate;
            rr_ptr     <= n_rr_ptr;
            owner      <= n_owner;
            beats_left <= n_beats_left;
        end
    end

    // Requests rotated so bit k is requester rr_ptr+k; the lowest set bit wins.
    assign rotated = {bus.req_write, bus.req_write} >> rr_ptr;

    always_comb begin
        grant = rr_ptr;
        found = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rotated[k]) begin
                grant = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
                found = 1'b1;
            end
        end
    end

    assign sel       = (state == BURST) ? owner : grant;
    assign accept    = bus.wr_write && !bus.wr_waitrequest;
    assign first_len = (bus.wr_burstcount == '0) ? BURST_W'(1) : bus.wr_burstcount;

    always_comb begin
        nstate       = state;
        n_rr_ptr     = rr_ptr;
        n_owner      = owner;
        n_beats_left = beats_left;
        if (accept && state == IDLE) begin
            nstate       = (first_len == BURST_W'(1)) ? IDLE : BURST;
            n_rr_ptr     = (first_len == BURST_W'(1)) ? next_idx(grant) : rr_ptr;
            n_owner      = grant;
            n_beats_left = first_len - BURST_W'(1);
        end else if (accept) begin
            nstate       = (beats_left == BURST_W'(1)) ? IDLE : BURST;
            n_rr_ptr     = (beats_left == BURST_W'(1)) ? next_idx(owner) : rr_ptr;
            n_beats_left = beats_left - BURST_W'(1);
        end
    end

    always_comb begin
        bus.wr_write        = reset_n && bus.req_write[sel];
        bus.wr_address      = bus.req_address[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
        bus.wr_writedata    = bus.req_writedata[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
        bus.wr_burstcount   = bus.req_burstcount[int'(sel)*BURST_W +: BURST_W];
        bus.wr_byteenable   = bus.req_byteenable[int'(sel)*BE_W +: BE_W];
        bus.wr_user         = USER_WIDTH'(sel);
        bus.req_waitrequest = '1;
        if (reset_n && (state == BURST || found))
            bus.req_waitrequest[sel] = bus.wr_waitrequest;
        for (int i = 0; i < NUM_REQ; i++)
            bus.req_wr_rsp_valid[i] = reset_n && bus.wr_rsp_valid && bus.wr_rsp_user == USER_WIDTH'(i);
    end

`ifdef ARB_WR_STATS_EN
    logic [31:0] bursts [NUM_REQ];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REQ; i++)
                bursts[i] <= '0;
            stat_bursts <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++)
                if (accept && state == IDLE && grant == IDX_W'(i) && bursts[i] != '1)
                    bursts[i] <= bursts[i] + 32'd1;
            stat_bursts <= (int'(stat_sel) < NUM_REQ) ? bursts[stat_sel] : '0;
        end
    end
`else
    logic unused_stat_sel;
    assign unused_stat_sel = ^stat_sel;
    assign stat_bursts     = '0;
`endif
endmodule
